// File: rtl/string_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : string_frame_sequencer
//  Description : Per-string frame sequencer. Pulls pixels from the pixel FIFO,
//                paces them to the WS2812B driver, then requests h_blank.
//  Revision    : 1.0  initial release
// ============================================================================
module string_frame_sequencer #(
    parameter int PIX_W = 24,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic [CNT_W-1:0] cfg_led_count,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [PIX_W-1:0] fifo_data,
    output logic [PIX_W-1:0] pixel_data,
    output logic             pixel_data_valid,
    output logic             h_blank,
    input  logic             string_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun,
    output logic             frame_drop
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_FETCH     = 3'd1;
    localparam logic [2:0] c_ST_LOAD      = 3'd2;
    localparam logic [2:0] c_ST_SEND      = 3'd3;
    localparam logic [2:0] c_ST_SETTLE    = 3'd4;
    localparam logic [2:0] c_ST_BLANK     = 3'd5;
    localparam logic [2:0] c_ST_BLANK_ACK = 3'd6;
    localparam logic [2:0] c_ST_DONE      = 3'd7;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_remain;
    logic [PIX_W-1:0] r_pixel;
    logic             r_valid;
    logic             r_blank;
    logic             r_busy;
    logic             r_done;
    logic             r_under;
    logic             w_accept;

    // busy stays high through the frame_done cycle, so a start there is dropped
    assign w_accept = frame_start && !r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_remain <= '0;
            r_pixel  <= '0;
            r_valid  <= 1'b0;
            r_blank  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_under  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_under <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_busy   <= 1'b1;
                        r_remain <= cfg_led_count;
                        r_state  <= (cfg_led_count == '0) ? c_ST_BLANK : c_ST_FETCH;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                c_ST_FETCH: begin
                    if (string_ready) begin
                        if (!fifo_empty) begin
                            r_state <= c_ST_LOAD;
                        end else begin
                            // Substitute black rather than stall the string timing
                            r_pixel <= '0;
                            r_under <= 1'b1;
                            r_valid <= 1'b1;
                            r_state <= c_ST_SEND;
                        end
                    end
                end
                c_ST_LOAD: begin
                    r_pixel <= fifo_data;
                    r_valid <= 1'b1;
                    r_state <= c_ST_SEND;
                end
                c_ST_SEND: begin
                    if (r_remain != '0) begin
                        r_remain <= r_remain - c_CNT_ONE;
                    end
                    r_state <= c_ST_SETTLE;
                end
                c_ST_SETTLE: begin
                    r_state <= (r_remain != '0) ? c_ST_FETCH : c_ST_BLANK;
                end
                c_ST_BLANK: begin
                    if (string_ready) begin
                        r_blank <= 1'b1;
                        r_state <= c_ST_BLANK_ACK;
                    end
                end
                c_ST_BLANK_ACK: begin
                    if (!string_ready) begin
                        r_blank <= 1'b0;
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (string_ready) begin
                        r_done  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Read strobe and drop flag must land in the same cycle as their cause
    assign fifo_rd_en       = (r_state == c_ST_FETCH) && string_ready && !fifo_empty;
    assign frame_drop       = frame_start && r_busy;

    assign pixel_data       = r_pixel;
    assign pixel_data_valid = r_valid;
    assign h_blank          = r_blank;
    assign busy             = r_busy;
    assign frame_done       = r_done;
    assign underrun         = r_under;

endmodule
`default_nettype wire
